// File: rtl/nand_phy_pkg.sv
// Shared NAND PHY definitions: DQS calibration FSM states and tap/settle constants.
package nand_phy_pkg;

    localparam int DQS_TAP_W  = 5;
    localparam int MIN_SETTLE = 3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SETTLE,
        ST_REQ,
        ST_NEXT,
        ST_CENTER,
        ST_FINISH
    } dqs_cal_state_t;

endpackage

// File: rtl/nand_dqs_win_track.sv
// Pass/fail run tracker for a DQS tap sweep: keeps the open run and the longest closed run.
module nand_dqs_win_track #(
    parameter int TAP_W = 5
) (
    input  logic             clk0,
    input  logic             rst0_n,
    input  logic             clr_i,
    input  logic             upd_i,
    input  logic             pass_i,
    input  logic             last_i,
    input  logic [TAP_W-1:0] tap_i,
    output logic [TAP_W-1:0] best_start_o,
    output logic [TAP_W:0]   best_len_o
);

    localparam logic [TAP_W:0] LEN_ONE = 1;

    logic             run_open_q;
    logic [TAP_W-1:0] run_start_q;
    logic [TAP_W:0]   run_len_q;
    logic [TAP_W-1:0] best_start_q;
    logic [TAP_W:0]   best_len_q;

    logic             cur_open_d;
    logic [TAP_W-1:0] cur_start_d;
    logic [TAP_W:0]   cur_len_d;
    logic             closing_d;

    // The run as it stands after this result; a fail leaves the previous run to be closed.
    always_comb begin
        cur_open_d  = 1'b0;
        cur_start_d = run_start_q;
        cur_len_d   = run_len_q;
        if (pass_i) begin
            cur_open_d  = 1'b1;
            cur_start_d = run_open_q ? run_start_q : tap_i;
            cur_len_d   = run_open_q ? (run_len_q + LEN_ONE) : LEN_ONE;
        end
        closing_d = (!pass_i && run_open_q) || (last_i && cur_open_d);
    end

    always_ff @(posedge clk0 or negedge rst0_n) begin
        if (!rst0_n) begin
            run_open_q   <= 1'b0;
            run_start_q  <= '0;
            run_len_q    <= '0;
            best_start_q <= '0;
            best_len_q   <= '0;
        end else if (clr_i) begin
            run_open_q   <= 1'b0;
            run_start_q  <= '0;
            run_len_q    <= '0;
            best_start_q <= '0;
            best_len_q   <= '0;
        end else if (upd_i) begin
            // Strictly longer only, so the earliest window wins a tie.
            if (closing_d && (cur_len_d > best_len_q)) begin
                best_start_q <= cur_start_d;
                best_len_q   <= cur_len_d;
            end
            run_open_q  <= cur_open_d && !last_i;
            run_start_q <= cur_start_d;
            run_len_q   <= cur_open_d ? cur_len_d : '0;
        end
    end

    assign best_start_o = best_start_q;
    assign best_len_o   = best_len_q;

endmodule

// File: rtl/nand_dqs_tap_cal.sv
// Per-channel DQS IDELAY tap owner with manual loads and a sweep-and-centre calibrator.
module nand_dqs_tap_cal
    import nand_phy_pkg::*;
#(
    parameter int NUM_DQS     = 1,
    parameter int TAP_W       = DQS_TAP_W,
    parameter int IDELAY_TAP  = 16,
    parameter int SETTLE_CYC  = 8,
    parameter int TIMEOUT_CYC = 1024,
    parameter int CH_W        = (NUM_DQS > 1) ? $clog2(NUM_DQS) : 1
) (
    input  logic                     clk0,
    input  logic                     rst0_n,
    input  logic                     cal_start,
    input  logic [CH_W-1:0]          cal_ch,
    input  logic                     man_ld,
    input  logic [CH_W-1:0]          man_ch,
    input  logic [TAP_W-1:0]         man_tap,
    output logic                     chk_req,
    input  logic                     chk_valid,
    input  logic                     chk_pass,
    output logic [NUM_DQS*TAP_W-1:0] dlyval_dqs,
    output logic [NUM_DQS-1:0]       dlyld_dqs,
    output logic                     cal_busy,
    output logic                     cal_done,
    output logic                     cal_err,
    output logic [TAP_W-1:0]         win_lo,
    output logic [TAP_W-1:0]         win_hi
);

    localparam int SETTLE_EFF = (SETTLE_CYC < MIN_SETTLE) ? MIN_SETTLE : SETTLE_CYC;
    localparam int CNT_W      = $clog2(TIMEOUT_CYC + SETTLE_EFF) + 1;
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_EFF - 1);
    localparam logic [CNT_W-1:0] TMO_LAST    = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [TAP_W:0]   LEN_ONE     = 1;

    dqs_cal_state_t   state_q;
    logic [CH_W-1:0]  ch_q;
    logic [TAP_W-1:0] saved_q;
    logic [TAP_W-1:0] tap_q;
    logic [CNT_W-1:0] cnt_q;
    logic             pass_q;
    logic             chk_req_q;
    logic             busy_q;
    logic             done_q;
    logic             err_q;
    logic [TAP_W-1:0] win_lo_q;
    logic [TAP_W-1:0] win_hi_q;

    logic [TAP_W-1:0]   lane_q [NUM_DQS];
    logic [NUM_DQS-1:0] dlyld_q;

    logic             cal_ok_d;
    logic             man_ok_d;
    logic             got_rsp_d;
    logic             tmo_d;
    logic [TAP_W-1:0] cur_tap_d;
    logic             ld_go_d;
    logic [CH_W-1:0]  ld_ch_d;
    logic [TAP_W-1:0] ld_val_d;

    logic [TAP_W-1:0] best_start;
    logic [TAP_W:0]   best_len;
    logic [TAP_W:0]   len_m1;
    logic [TAP_W:0]   ctr_full;
    logic [TAP_W:0]   hi_full;

    assign cal_ok_d  = int'(cal_ch) < NUM_DQS;
    assign man_ok_d  = int'(man_ch) < NUM_DQS;
    assign got_rsp_d = chk_valid && chk_req_q;
    assign tmo_d     = !got_rsp_d && (cnt_q == TMO_LAST);

    assign len_m1   = best_len - LEN_ONE;
    assign ctr_full = {1'b0, best_start} + (len_m1 >> 1);
    assign hi_full  = {1'b0, best_start} + len_m1;

    always_comb begin
        cur_tap_d = lane_q[0];
        for (int i = 1; i < NUM_DQS; i++) begin
            if (int'(cal_ch) == i) cur_tap_d = lane_q[i];
        end
    end

    // One lane write per cycle at most: manual load, sweep step, restore or centre.
    always_comb begin
        ld_go_d  = 1'b0;
        ld_ch_d  = ch_q;
        ld_val_d = tap_q;
        case (state_q)
            ST_IDLE: begin
                if (!cal_start && man_ld && man_ok_d) begin
                    ld_go_d  = 1'b1;
                    ld_ch_d  = man_ch;
                    ld_val_d = man_tap;
                end
            end
            ST_LOAD: ld_go_d = 1'b1;
            ST_REQ: begin
                if (tmo_d) begin
                    ld_go_d  = 1'b1;
                    ld_val_d = saved_q;
                end
            end
            ST_CENTER: begin
                ld_go_d  = 1'b1;
                ld_val_d = (best_len == '0) ? saved_q : ctr_full[TAP_W-1:0];
            end
            default: ;
        endcase
    end

    // Lanes start at the IOB power-up value, so reset issues no strobe.
    always_ff @(posedge clk0 or negedge rst0_n) begin
        if (!rst0_n) begin
            for (int i = 0; i < NUM_DQS; i++) lane_q[i] <= TAP_W'(IDELAY_TAP);
            dlyld_q <= '0;
        end else begin
            for (int i = 0; i < NUM_DQS; i++) begin
                dlyld_q[i] <= ld_go_d && (int'(ld_ch_d) == i);
                if (ld_go_d && (int'(ld_ch_d) == i)) lane_q[i] <= ld_val_d;
            end
        end
    end

    always_ff @(posedge clk0 or negedge rst0_n) begin
        if (!rst0_n) begin
            state_q   <= ST_IDLE;
            ch_q      <= '0;
            saved_q   <= '0;
            tap_q     <= '0;
            cnt_q     <= '0;
            pass_q    <= 1'b0;
            chk_req_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            win_lo_q  <= '0;
            win_hi_q  <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (cal_start) begin
                        err_q <= 1'b0;
                        if (cal_ok_d) begin
                            ch_q    <= cal_ch;
                            saved_q <= cur_tap_d;
                            tap_q   <= '0;
                            busy_q  <= 1'b1;
                            state_q <= ST_LOAD;
                        end else begin
                            err_q  <= 1'b1;
                            done_q <= 1'b1;
                        end
                    end
                end
                ST_LOAD: begin
                    cnt_q   <= '0;
                    state_q <= ST_SETTLE;
                end
                ST_SETTLE: begin
                    if (cnt_q == SETTLE_LAST) begin
                        cnt_q     <= '0;
                        chk_req_q <= 1'b1;
                        state_q   <= ST_REQ;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_REQ: begin
                    if (got_rsp_d) begin
                        pass_q    <= chk_pass;
                        chk_req_q <= 1'b0;
                        state_q   <= ST_NEXT;
                    end else if (tmo_d) begin
                        err_q     <= 1'b1;
                        chk_req_q <= 1'b0;
                        done_q    <= 1'b1;
                        state_q   <= ST_FINISH;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_NEXT: begin
                    if (&tap_q) begin
                        state_q <= ST_CENTER;
                    end else begin
                        tap_q   <= tap_q + 1'b1;
                        state_q <= ST_LOAD;
                    end
                end
                ST_CENTER: begin
                    if (best_len == '0) begin
                        err_q <= 1'b1;
                    end else begin
                        win_lo_q <= best_start;
                        win_hi_q <= hi_full[TAP_W-1:0];
                    end
                    done_q  <= 1'b1;
                    state_q <= ST_FINISH;
                end
                ST_FINISH: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    busy_q    <= 1'b0;
                    chk_req_q <= 1'b0;
                    state_q   <= ST_IDLE;
                end
            endcase
        end
    end

    nand_dqs_win_track #(
        .TAP_W(TAP_W)
    ) u_win_track (
        .clk0        (clk0),
        .rst0_n      (rst0_n),
        .clr_i       ((state_q == ST_IDLE) && cal_start && cal_ok_d),
        .upd_i       (state_q == ST_NEXT),
        .pass_i      (pass_q),
        .last_i      (&tap_q),
        .tap_i       (tap_q),
        .best_start_o(best_start),
        .best_len_o  (best_len)
    );

    for (genvar g = 0; g < NUM_DQS; g++) begin : g_lane
        assign dlyval_dqs[g*TAP_W +: TAP_W] = lane_q[g];
    end

    assign dlyld_dqs = dlyld_q;
    assign chk_req   = chk_req_q;
    assign cal_busy  = busy_q;
    assign cal_done  = done_q;
    assign cal_err   = err_q;
    assign win_lo    = win_lo_q;
    assign win_hi    = win_hi_q;

endmodule

// File: tb/tb_nand_dqs_tap_cal.sv
// Directed bench for nand_dqs_tap_cal: manual loads, window search, errors, timeout and reset abort.
module tb_nand_dqs_tap_cal;

    localparam int NUM_DQS = 3;
    localparam int TAP_W   = 5;
    localparam int CH_W    = 2;
    localparam int TMO     = 64;

    logic                     clk0 = 1'b0;
    logic                     rst0_n = 1'b0;
    logic                     cal_start = 1'b0;
    logic [CH_W-1:0]          cal_ch = '0;
    logic                     man_ld = 1'b0;
    logic [CH_W-1:0]          man_ch = '0;
    logic [TAP_W-1:0]         man_tap = '0;
    logic                     chk_req;
    logic                     chk_valid;
    logic                     chk_pass;
    logic [NUM_DQS*TAP_W-1:0] dlyval_dqs;
    logic [NUM_DQS-1:0]       dlyld_dqs;
    logic                     cal_busy;
    logic                     cal_done;
    logic                     cal_err;
    logic [TAP_W-1:0]         win_lo;
    logic [TAP_W-1:0]         win_hi;

    int n_pass = 0;
    int n_total = 0;

    // checker model state
    logic [31:0]      rsp_mask = '0;
    int               cal_lane = 0;
    int               hs_cnt = 0;
    logic             silent_en = 1'b0;
    logic [TAP_W-1:0] silent_tap = '0;
    int               silent_cnt = 0;
    int               ld0_cnt = 0;

    nand_dqs_tap_cal #(
        .NUM_DQS    (NUM_DQS),
        .TAP_W      (TAP_W),
        .IDELAY_TAP (16),
        .SETTLE_CYC (3),
        .TIMEOUT_CYC(TMO),
        .CH_W       (CH_W)
    ) dut (
        .clk0      (clk0),
        .rst0_n    (rst0_n),
        .cal_start (cal_start),
        .cal_ch    (cal_ch),
        .man_ld    (man_ld),
        .man_ch    (man_ch),
        .man_tap   (man_tap),
        .chk_req   (chk_req),
        .chk_valid (chk_valid),
        .chk_pass  (chk_pass),
        .dlyval_dqs(dlyval_dqs),
        .dlyld_dqs (dlyld_dqs),
        .cal_busy  (cal_busy),
        .cal_done  (cal_done),
        .cal_err   (cal_err),
        .win_lo    (win_lo),
        .win_hi    (win_hi)
    );

    always #5 clk0 = ~clk0;

    function automatic logic [TAP_W-1:0] get_lane(input int ch);
        logic [NUM_DQS*TAP_W-1:0] t;
        t = dlyval_dqs >> (ch * TAP_W);
        return t[TAP_W-1:0];
    endfunction

    always @(negedge clk0) begin
        if (dlyld_dqs[0] === 1'b1) ld0_cnt++;
    end

    // Read-data checker stand-in: answers each request two cycles later from rsp_mask.
    initial begin
        logic [TAP_W-1:0] rtap;
        chk_valid = 1'b0;
        chk_pass  = 1'b0;
        forever begin
            @(negedge clk0);
            if (chk_req === 1'b1) begin
                rtap = get_lane(cal_lane);
                if (silent_en && rtap == silent_tap) begin
                    silent_cnt = 0;
                    while (chk_req === 1'b1) begin
                        silent_cnt++;
                        @(negedge clk0);
                    end
                end else begin
                    @(negedge clk0);
                    chk_valid = 1'b1;
                    chk_pass  = rsp_mask[rtap];
                    hs_cnt++;
                    @(negedge clk0);
                    chk_valid = 1'b0;
                    chk_pass  = 1'b0;
                end
            end
        end
    end

    task automatic start_cal(input logic [CH_W-1:0] ch, input logic [31:0] mask);
        rsp_mask = mask;
        cal_lane = int'(ch);
        hs_cnt   = 0;
        @(negedge clk0);
        cal_start = 1'b1;
        cal_ch    = ch;
        @(negedge clk0);
        cal_start = 1'b0;
    endtask

    task automatic wait_done(output logic seen);
        seen = 1'b0;
        for (int i = 0; i < 6000 && !seen; i++) begin
            if (cal_done === 1'b1) seen = 1'b1;
            else @(negedge clk0);
        end
    endtask

    task automatic test_reset;
        n_total++; if (dlyld_dqs !== 3'b000) $display("FAIL reset_dlyld got %b want 000", dlyld_dqs); else n_pass++;
        for (int i = 0; i < NUM_DQS; i++) begin
            n_total++;
            if (get_lane(i) !== 5'd16) $display("FAIL reset_lane%0d got %0d want 16", i, get_lane(i)); else n_pass++;
        end
        n_total++;
        if ({chk_req, cal_busy, cal_done, cal_err} !== 4'b0000)
            $display("FAIL reset_flags got req/busy/done/err=%b want 0000", {chk_req, cal_busy, cal_done, cal_err});
        else n_pass++;
        n_total++;
        if ({win_lo, win_hi} !== 10'd0) $display("FAIL reset_win got lo=%0d hi=%0d want 0/0", win_lo, win_hi); else n_pass++;
    endtask

    task automatic test_manual;
        @(negedge clk0);
        man_ld = 1'b1; man_ch = 2'd0; man_tap = 5'd7;
        @(negedge clk0);
        man_ld = 1'b0;
        n_total++; if (dlyld_dqs !== 3'b001) $display("FAIL man_strobe got %b want 001", dlyld_dqs); else n_pass++;
        n_total++; if (get_lane(0) !== 5'd7) $display("FAIL man_lane0 got %0d want 7", get_lane(0)); else n_pass++;
        n_total++; if (get_lane(1) !== 5'd16) $display("FAIL man_lane1 got %0d want 16", get_lane(1)); else n_pass++;
        @(negedge clk0);
        n_total++; if (dlyld_dqs !== 3'b000) $display("FAIL man_strobe_end got %b want 000", dlyld_dqs); else n_pass++;
        n_total++; if (get_lane(0) !== 5'd7) $display("FAIL man_hold got %0d want 7", get_lane(0)); else n_pass++;
    endtask

    task automatic test_bad_channel;
        @(negedge clk0);
        cal_start = 1'b1; cal_ch = 2'd3;
        @(negedge clk0);
        cal_start = 1'b0;
        n_total++;
        if ({cal_done, cal_err, cal_busy} !== 3'b110)
            $display("FAIL badch_flags got done/err/busy=%b want 110", {cal_done, cal_err, cal_busy});
        else n_pass++;
        @(negedge clk0);
        n_total++;
        if ({cal_done, cal_err} !== 2'b01) $display("FAIL badch_after got done/err=%b want 01", {cal_done, cal_err}); else n_pass++;
    endtask

    task automatic test_window(input string name, input logic [31:0] mask,
                               input logic [4:0] lo, input logic [4:0] hi, input logic [4:0] tap);
        logic seen;
        start_cal(2'd1, mask);
        wait_done(seen);
        n_total++; if (seen !== 1'b1) $display("FAIL %s_done got %b want 1", name, seen); else n_pass++;
        n_total++; if (win_lo !== lo) $display("FAIL %s_lo got %0d want %0d", name, win_lo, lo); else n_pass++;
        n_total++; if (win_hi !== hi) $display("FAIL %s_hi got %0d want %0d", name, win_hi, hi); else n_pass++;
        n_total++; if (get_lane(1) !== tap) $display("FAIL %s_tap got %0d want %0d", name, get_lane(1), tap); else n_pass++;
        n_total++; if (cal_err !== 1'b0) $display("FAIL %s_err got %b want 0", name, cal_err); else n_pass++;
        n_total++; if (hs_cnt !== 32) $display("FAIL %s_handshakes got %0d want 32", name, hs_cnt); else n_pass++;
        @(negedge clk0);
        n_total++;
        if ({cal_done, cal_busy} !== 2'b00) $display("FAIL %s_idle got done/busy=%b want 00", name, {cal_done, cal_busy}); else n_pass++;
    endtask

    task automatic test_all_fail;
        logic seen;
        start_cal(2'd1, 32'h0000_0000);
        wait_done(seen);
        n_total++; if (seen !== 1'b1) $display("FAIL allfail_done got %b want 1", seen); else n_pass++;
        n_total++; if (cal_err !== 1'b1) $display("FAIL allfail_err got %b want 1", cal_err); else n_pass++;
        n_total++; if (get_lane(1) !== 5'd29) $display("FAIL allfail_restore got %0d want 29", get_lane(1)); else n_pass++;
        n_total++; if ({win_lo, win_hi} !== {5'd28, 5'd31}) $display("FAIL allfail_win got %0d..%0d want 28..31", win_lo, win_hi); else n_pass++;
        @(negedge clk0);
        n_total++; if (cal_done !== 1'b0) $display("FAIL allfail_pulse got %b want 0", cal_done); else n_pass++;
    endtask

    task automatic test_timeout;
        logic seen;
        @(negedge clk0);
        man_ld = 1'b1; man_ch = 2'd2; man_tap = 5'd21;
        @(negedge clk0);
        man_ld = 1'b0;
        silent_en = 1'b1; silent_tap = 5'd4; silent_cnt = 0;
        start_cal(2'd2, 32'hFFFF_FFFF);
        wait_done(seen);
        silent_en = 1'b0;
        n_total++; if (seen !== 1'b1) $display("FAIL tmo_done got %b want 1", seen); else n_pass++;
        n_total++; if (cal_err !== 1'b1) $display("FAIL tmo_err got %b want 1", cal_err); else n_pass++;
        n_total++; if (get_lane(2) !== 5'd21) $display("FAIL tmo_restore got %0d want 21", get_lane(2)); else n_pass++;
        n_total++; if (silent_cnt !== TMO) $display("FAIL tmo_req_cycles got %0d want %0d", silent_cnt, TMO); else n_pass++;
        n_total++; if (hs_cnt !== 4) $display("FAIL tmo_handshakes got %0d want 4", hs_cnt); else n_pass++;
        @(negedge clk0);
    endtask

    task automatic test_man_during_sweep;
        logic seen;
        int   ld0_before;
        ld0_before = ld0_cnt;
        start_cal(2'd1, 32'h001F_FC00);
        repeat (20) @(negedge clk0);
        man_ld = 1'b1; man_ch = 2'd0; man_tap = 5'd9;
        @(negedge clk0);
        man_ld = 1'b0;
        wait_done(seen);
        n_total++; if (seen !== 1'b1) $display("FAIL mansweep_done got %b want 1", seen); else n_pass++;
        n_total++; if (get_lane(0) !== 5'd7) $display("FAIL mansweep_lane0 got %0d want 7", get_lane(0)); else n_pass++;
        n_total++; if (ld0_cnt !== ld0_before) $display("FAIL mansweep_strobe got %0d strobes want 0", ld0_cnt - ld0_before); else n_pass++;
        n_total++; if (get_lane(1) !== 5'd15) $display("FAIL mansweep_tap got %0d want 15", get_lane(1)); else n_pass++;
        @(negedge clk0);
    endtask

    task automatic test_start_with_man;
        logic seen;
        int   ld0_before;
        ld0_before = ld0_cnt;
        rsp_mask = 32'h00F0_003C; cal_lane = 1; hs_cnt = 0;
        @(negedge clk0);
        cal_start = 1'b1; cal_ch = 2'd1;
        man_ld = 1'b1; man_ch = 2'd0; man_tap = 5'd3;
        @(negedge clk0);
        cal_start = 1'b0; man_ld = 1'b0;
        n_total++; if (cal_busy !== 1'b1) $display("FAIL both_busy got %b want 1", cal_busy); else n_pass++;
        wait_done(seen);
        n_total++; if (seen !== 1'b1) $display("FAIL both_done got %b want 1", seen); else n_pass++;
        n_total++; if (get_lane(0) !== 5'd7) $display("FAIL both_lane0 got %0d want 7", get_lane(0)); else n_pass++;
        n_total++; if (ld0_cnt !== ld0_before) $display("FAIL both_strobe got %0d strobes want 0", ld0_cnt - ld0_before); else n_pass++;
        n_total++; if (get_lane(1) !== 5'd3) $display("FAIL both_tap got %0d want 3", get_lane(1)); else n_pass++;
        @(negedge clk0);
    endtask

    task automatic test_reset_mid_sweep;
        logic seen;
        int   strobes;
        start_cal(2'd1, 32'hFFFF_FFFF);
        seen = 1'b0;
        for (int i = 0; i < 3000 && !seen; i++) begin
            if (get_lane(1) == 5'd12 && cal_busy === 1'b1) seen = 1'b1;
            else @(negedge clk0);
        end
        n_total++; if (seen !== 1'b1) $display("FAIL rstmid_reach12 got %b want 1", seen); else n_pass++;
        rst0_n = 1'b0;
        #1;
        for (int i = 0; i < NUM_DQS; i++) begin
            n_total++;
            if (get_lane(i) !== 5'd16) $display("FAIL rstmid_lane%0d got %0d want 16", i, get_lane(i)); else n_pass++;
        end
        n_total++;
        if ({cal_busy, chk_req, cal_done, cal_err, dlyld_dqs} !== 7'd0)
            $display("FAIL rstmid_flags got busy/req/done/err/ld=%b want 0", {cal_busy, chk_req, cal_done, cal_err, dlyld_dqs});
        else n_pass++;
        repeat (3) @(negedge clk0);
        rst0_n = 1'b1;
        strobes = 0;
        repeat (6) begin
            @(negedge clk0);
            if (dlyld_dqs !== 3'b000) strobes++;
        end
        n_total++; if (strobes !== 0) $display("FAIL rstmid_nostrobe got %0d strobe cycles want 0", strobes); else n_pass++;
        test_window("rstmid_recal", 32'h001F_FC00, 5'd10, 5'd20, 5'd15);
    endtask

    initial begin
        repeat (3) @(negedge clk0);
        test_reset;
        rst0_n = 1'b1;
        @(negedge clk0);
        test_manual;
        test_bad_channel;
        test_window("win10_20", 32'h001F_FC00, 5'd10, 5'd20, 5'd15);
        test_window("two_win", 32'h00F0_003C, 5'd2, 5'd5, 5'd3);
        test_window("top_win", 32'hF000_0000, 5'd28, 5'd31, 5'd29);
        test_all_fail;
        test_window("all_pass", 32'hFFFF_FFFF, 5'd0, 5'd31, 5'd15);
        test_timeout;
        test_man_during_sweep;
        test_start_with_man;
        test_reset_mid_sweep;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
